// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider:
// FSM state encoding, default operand width and counter sizing.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    // Iteration counter must hold the value WIDTH itself.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // Counter width for an arbitrary operand width.
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_nr_step.sv
// Combinational single non-restoring division step.
// P is the (WIDTH+1)-bit signed partial remainder, Q the dividend/quotient
// shift register, D the divisor magnitude.
module div_nr_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] d_ext;

    // Shift in the next dividend bit, then subtract D when P>=0, add it when P<0.
    always_comb begin
        // NOTE: every signal driven here gets a value first on all paths, so no latch is inferred.
        shifted = {p[WIDTH-1:0], q[WIDTH-1]};
        d_ext   = {1'b0, d};
        p_next  = '0;
        if (!p[WIDTH]) begin
            p_next = shifted - d_ext;
        end else begin
            p_next = shifted + d_ext;
        end
        q_next = {q[WIDTH-2:0], ~p_next[WIDTH]};
    end

endmodule

// File: rtl/divide_nonrestoring_seq.sv
// Sequential non-restoring integer divider, one quotient bit per clock,
// start/busy/done handshake, results held until the next accepted start.
// Define DIV_SIGNED_EN for two's-complement operands (truncating quotient,
// remainder carries the dividend's sign); default build is unsigned.
module divide_nonrestoring_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] r_fixed;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    div_nr_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_reg),
        .q      (q_reg),
        .d      (d_reg),
        .p_next (p_next),
        .q_next (q_next)
    );

    // A negative final partial remainder is restored by adding D back once.
    assign r_fixed = p_reg[WIDTH] ? (p_reg[WIDTH-1:0] + d_reg) : p_reg[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // The core divides magnitudes; signs are reapplied when results are written.
    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign res_q = neg_q ? -q_reg   : q_reg;
    assign res_r = neg_r ? -r_fixed : r_fixed;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign res_q = q_reg;
    assign res_r = r_fixed;
`endif

    // Control FSM and datapath registers, all outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            p_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        p_reg <= '0;
                        q_reg <= a_mag;
                        d_reg <= b_mag;
                        cnt   <= CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
                        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    p_reg <= p_next;
                    q_reg <= q_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= res_q;
                    remainder   <= res_r;
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divide_nonrestoring_seq.sv
// Self-checking bench for divide_nonrestoring_seq: directed cases plus
// randomized operands against a plain-arithmetic reference model.
module tb_divide_nonrestoring_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    divide_nonrestoring_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
        int sa;
        int sb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            z = 1'b0;
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            sa = int'(a);
            sb = int'(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`endif
        end
    endtask

    // Issue one division and check timing, results, pulse width and hold.
    // With poke set, a second start (9/3) is pulsed in cycle 4 and must be ignored.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        bit           ez;
        int           done_at;
        bit           busy_bad;
        bit           exp_busy;
        model(a, b, eq, er, ez);
        done_at  = 0;
        busy_bad = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        for (int n = 1; n <= 40 && done_at == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (poke && n == 4) begin
                start    = 1'b1;
                dividend = 16'd9;
                divisor  = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) done_at = n;
            exp_busy = ez ? 1'b0 : (n <= W + 1);
            if (busy !== exp_busy) busy_bad = 1'b1;
        end
        start = 1'b0;
        check("done_cycle", done_at, ez ? 1 : W + 2);
        check("busy_window", {31'd0, busy_bad}, 0);
        if (done_at != 0) begin
            check("quotient", quotient, eq);
            check("remainder", remainder, er);
            check("div_by_zero", div_by_zero, ez);
        end
        @(negedge clk);
        check("done_pulse", done, 0);
        check("quotient_hold", quotient, eq);
        check("remainder_hold", remainder, er);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           saw_done;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        run_div(16'd100, 16'd7, 1'b0);
        run_div(16'd5, 16'd0, 1'b0);
`ifdef DIV_SIGNED_EN
        run_div(16'hFFF9, 16'd2, 1'b0);
        run_div(16'd7, 16'hFFFE, 1'b0);
        run_div(16'h8000, 16'hFFFF, 1'b0);
`else
        run_div(16'hFFFF, 16'd1, 1'b0);
`endif

        // Ignored mid-flight start, then results held for a while.
        run_div(16'd50, 16'd5, 1'b1);
        repeat (5) @(negedge clk);
        check("idle_hold_q", quotient, 16'd10);
        check("idle_hold_r", remainder, 16'd0);

        // Reset in the middle of a division discards it.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd3;
        @(negedge clk);
        start    = 1'b0;
        saw_done = 1'b0;
        for (int n = 1; n < 8; n++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_quotient", quotient, 0);
        check("mid_rst_remainder", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("mid_rst_no_done", {31'd0, saw_done}, 0);
        run_div(16'd9, 16'd3, 1'b0);

        // Boundary and random operands.
        run_div(16'd0, 16'd9, 1'b0);
        run_div(16'd3, 16'd9, 1'b0);
        run_div(16'd1234, 16'd1234, 1'b0);
        run_div(16'hFFFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            run_div(ra, rb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
